sc_datamem_io: RTL
==================

# sc_datamem_io

Parametrised data memory for the single-cycle CPU: a word-organised RAM with byte/halfword/word access, sign/zero-extending loads, and an integrated memory-mapped I/O region (sampled input ports, registered output ports, free-running cycle timer, misalignment status). It sits between the ALU address output and the register-file write-back mux. It replaces the split-phase RAM wrapper with a single-edge design: combinational read, rising-edge write.

## Interface
- DEPTH_LOG2, 5, log2 of RAM depth in 32-bit words; RAM is indexed by addr[DEPTH_LOG2+1:2].
- IO_SEL_BIT, 7, address bit that selects the I/O region; must satisfy DEPTH_LOG2+2 <= IO_SEL_BIT.
- IO_IN_N, 2, number of 32-bit input ports (1..8).
- IO_OUT_N, 2, number of 32-bit output ports (1..8).
- clock  in  1  system clock, all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- addr  in  32  byte address.
- datain  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- we  in  1  store enable.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- dataout  out  32  load data, combinational from current inputs and state.
- misalign  out  1  combinational: current access is misaligned.
- in_port  in  32*IO_IN_N  external inputs; port k is in_port[32k+31:32k].
- out_port  out  32*IO_OUT_N  registered outputs; port k is out_port[32k+31:32k].

## Operation
- Region select: addr[IO_SEL_BIT]=0 is RAM, 1 is I/O. RAM addr bits above DEPTH_LOG2+1 (below IO_SEL_BIT) are ignored (aliasing).
- I/O word offset is addr[6:2]: 0..IO_IN_N-1 input sample regs (read-only, writes ignored); 8..8+IO_OUT_N-1 output regs (R/W); 16 timer (R/W); 17 status (bit0 sticky misalign, write of any value with bit0=1 clears it); all other offsets read 0, writes ignored.
- Little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Then misalign=1, no state changes except sticky bit, dataout=0.
- Store: selected lanes of the target word replaced by the corresponding low bits of datain; other lanes unchanged. Sub-word stores to output regs and timer merge the same way.
- Load: target word selected, lane extracted, extended per load_unsigned to 32 bits. Word loads ignore load_unsigned.
- Input sample regs capture in_port every cycle (one-stage synchroniser; reads see value from previous edge).
- Timer: increments by 1 each cycle, wraps 0xFFFFFFFF -> 0. Aligned store to timer wins over increment: next-cycle value is the merged write value exactly (no +1 that cycle).
- Sticky misalign: set on any cycle with misalign=1 (load or store); a clear-write to status in the same cycle as a misalign is impossible (that access is itself aligned), so no conflict.

## Timing
- Load: zero latency; dataout valid combinationally in the same cycle as addr/size.
- Store: committed on the rising edge where we=1; read of same address in the next cycle returns new data. Same-cycle read of a stored address returns the old data.
- out_port updates on the edge of the store, visible immediately after.
- in_port to readable: 1 edge.
- Reset (resetn=0 on an edge): out_port=0, timer=0, input sample regs=0, sticky=0; stores ignored during reset. RAM contents not reset. Reset asserted mid-sequence drops the in-flight store. misalign and dataout stay combinational during reset (I/O reads return the reset values).

## Test plan
- Word store 0x12345678 to 0x04, then byte loads 0x04..0x07 unsigned -> 0x78,0x56,0x34,0x12; halfword load 0x06 signed -> 0x00001234.
- Byte store 0xAB to 0x09 over word 0x00000000 -> word load 0x08 = 0x0000AB00; signed byte load 0x09 = 0xFFFFFFAB.
- Halfword load 0x05 and word store to 0x0A -> misalign=1, dataout=0, RAM unchanged, status read 0x1; status write 0x1 -> status reads 0x0.
- Word store 0xDEADBEEF to 0x80+8*4 -> out_port[31:0]=0xDEADBEEF next edge; drive in_port[63:32]=0x55 -> load 0x84 returns 0x55 one cycle later, not before.
- After reset, timer load at cycle n reads n; store 0xFFFFFFFE to timer -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on following cycles.
- Assert resetn=0 for one edge with we=1 to an output reg -> out_port remains 0, timer 0, sticky 0.

Source files
------------

// File: rtl/sc_datamem_io.sv
// sc_datamem_io: single-edge data memory with memory-mapped I/O.
//   Word-organised RAM (combinational read, rising-edge write) with
//   byte/half/word access and sign/zero-extending loads. addr[IO_SEL_BIT]=1
//   selects the I/O region: input sample regs (offsets 0..), output regs
//   (offsets 8..), free-running timer (16), sticky misalign status (17).
// Ports:
//   clock, resetn        - clock, synchronous active-low reset
//   addr, datain, we     - byte address, right-aligned store data, store enable
//   size, load_unsigned  - 00 byte / 01 half / 1x word; zero-extend sub-word loads
//   dataout, misalign    - combinational load data and misalignment flag
//   in_port, out_port    - 32-bit external input ports / registered output ports
module sc_datamem_io #(
    parameter int DEPTH_LOG2 = 5,
    parameter int IO_SEL_BIT = 7,
    parameter int IO_IN_N    = 2,
    parameter int IO_OUT_N   = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [31:0]             addr,
    input  logic [31:0]             datain,
    input  logic                    we,
    input  logic [1:0]              size,
    input  logic                    load_unsigned,
    output logic [31:0]             dataout,
    output logic                    misalign,
    input  logic [32*IO_IN_N-1:0]   in_port,
    output logic [32*IO_OUT_N-1:0]  out_port
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]                   r_mem [DEPTH];
    logic [IO_IN_N-1:0][31:0]      r_in;
    logic [IO_OUT_N-1:0][31:0]     r_out;
    logic [31:0]                   r_timer;
    logic                          r_sticky;

    logic                          w_io;
    logic [4:0]                    w_off;
    logic [DEPTH_LOG2-1:0]         w_widx;
    logic [31:0]                   w_io_word;
    logic [31:0]                   w_rword;
    logic [3:0]                    w_bmask;
    logic [31:0]                   w_bitmask;
    logic [31:0]                   w_wdata;
    logic [31:0]                   w_merge;
    logic [31:0]                   w_shift;
    logic [15:0]                   w_half;
    logic                          w_wr;
    logic                          w_unused_addr;

    assign w_io     = addr[IO_SEL_BIT];
    assign w_off    = addr[6:2];
    assign w_widx   = addr[DEPTH_LOG2+1:2];
    assign out_port = r_out;
    // Address bits outside the decoded fields are deliberately ignored (aliasing).
    assign w_unused_addr = ^addr;

    assign misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign w_wr     = we && !misalign;

    // I/O word decode; unmapped offsets read as zero.
    always_comb begin
        w_io_word = '0;
        for (int k = 0; k < IO_IN_N; k++)
            if (w_off == 5'(k)) w_io_word = r_in[k];
        for (int k = 0; k < IO_OUT_N; k++)
            if (w_off == 5'(8 + k)) w_io_word = r_out[k];
        if (w_off == 5'd16) w_io_word = r_timer;
        if (w_off == 5'd17) w_io_word = {31'b0, r_sticky};
    end

    assign w_rword = w_io ? w_io_word : r_mem[w_widx];

    // Lane mask and replicated store data; the same merge serves RAM,
    // output regs and the timer.
    always_comb begin
        case (size)
            2'b00: begin
                w_bmask = 4'b0001 << addr[1:0];
                w_wdata = {4{datain[7:0]}};
            end
            2'b01: begin
                w_bmask = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{datain[15:0]}};
            end
            default: begin
                w_bmask = 4'b1111;
                w_wdata = datain;
            end
        endcase
        for (int i = 0; i < 4; i++)
            w_bitmask[8*i +: 8] = {8{w_bmask[i]}};
    end

    assign w_merge = (w_rword & ~w_bitmask) | (w_wdata & w_bitmask);

    // Load lane extraction and extension.
    assign w_shift = w_rword >> {addr[1:0], 3'b000};
    assign w_half  = addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        dataout = '0;
        if (!misalign) begin
            case (size)
                2'b00:   dataout = load_unsigned ? {24'b0, w_shift[7:0]}
                                                 : {{24{w_shift[7]}}, w_shift[7:0]};
                2'b01:   dataout = load_unsigned ? {16'b0, w_half}
                                                 : {{16{w_half[15]}}, w_half};
                default: dataout = w_rword;
            endcase
        end
    end

    // RAM is not reset; stores during reset are dropped.
    always_ff @(posedge clock) begin
        if (resetn && w_wr && !w_io)
            r_mem[w_widx] <= w_merge;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_in     <= '0;
            r_out    <= '0;
            r_timer  <= '0;
            r_sticky <= 1'b0;
        end else begin
            for (int k = 0; k < IO_IN_N; k++)
                r_in[k] <= in_port[32*k +: 32];
            // A timer store overrides the increment below.
            r_timer <= r_timer + 32'd1;
            if (misalign) r_sticky <= 1'b1;
            if (w_wr && w_io) begin
                for (int k = 0; k < IO_OUT_N; k++)
                    if (w_off == 5'(8 + k)) r_out[k] <= w_merge;
                if (w_off == 5'd16) r_timer <= w_merge;
                // Clear only if the written lanes include bit0 and it is set.
                if (w_off == 5'd17 && w_bmask[0] && w_wdata[0]) r_sticky <= 1'b0;
            end
        end
    end
endmodule
